// File: rtl/proc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ProcSeqCtrl -- multi-cycle instruction sequencer control block.
//
// Walks each instruction through FETCH -> DECODE -> EXE -> (MEM) -> WB.
// A memory timeout drops the sequencer into a sticky ERR state. A halt
// request parks it in HALT.
//
// Parameters
//   CNT_WIDTH  width of the retired-instruction counter
//   TIMEOUT    maximum consecutive not-ready cycles in FETCH/MEM (0 = never)
//   TO_WIDTH   width of the wait counter (must be able to hold TIMEOUT)
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_mem_ready  memory finishes the current FETCH/MEM access this cycle
//   i_stall      hold the sequencer in DECODE
//   i_need_mem   instruction needs a MEM stage (sampled in EXE)
//   i_mem_wr     MEM access is a store (1) or a load (0) (sampled in EXE)
//   i_halt_req   halt request (sampled in WB and HALT)
//   o_state      current state code
//   o_read       memory read strobe
//   o_write      memory write strobe
//   o_insn_cnt   retired-instruction count
//   o_bus_err    sticky memory-timeout flag
//   o_halted     sequencer is parked in HALT
// ---------------------------------------------------------------------------
module proc_seq_ctrl #(
   parameter int CNT_WIDTH = 32,
   parameter int TIMEOUT   = 15,
   parameter int TO_WIDTH  = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_mem_ready,
   input  logic                 i_stall,
   input  logic                 i_need_mem,
   input  logic                 i_mem_wr,
   input  logic                 i_halt_req,
   output logic [2:0]           o_state,
   output logic                 o_read,
   output logic                 o_write,
   output logic [CNT_WIDTH-1:0] o_insn_cnt,
   output logic                 o_bus_err,
   output logic                 o_halted
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXE    = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_ERR    = 3'd6,
      S_IDLE   = 3'd7
   } state_t;

   // The wait counter value in the last tolerated not-ready cycle. It is
   // only used when the timeout is enabled.
   localparam bit                  TO_EN     = (TIMEOUT > 0);
   localparam logic [TO_WIDTH-1:0] LAST_WAIT = TO_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t                r_state;
   logic [TO_WIDTH-1:0]   r_wait;
   logic                  r_need;
   logic                  r_store;
   logic [CNT_WIDTH-1:0]  r_cnt;

   // Main sequencer. The wait counter clears by default each cycle, so every
   // entry into FETCH or MEM starts from zero. It only counts up while
   // FETCH or MEM is waiting on memory. In the timeout cycle, ready takes
   // priority over the error transition.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_wait  <= '0;
         r_need  <= 1'b0;
         r_store <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_wait <= '0;
         case (r_state)
            S_IDLE: begin
               r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (i_mem_ready)
                  r_state <= S_DECODE;
               else if (TO_EN && (r_wait == LAST_WAIT))
                  r_state <= S_ERR;
               else
                  r_wait <= r_wait + 1'b1;
            end
            S_DECODE: begin
               if (!i_stall)
                  r_state <= S_EXE;
            end
            S_EXE: begin
               r_need  <= i_need_mem;
               r_store <= i_mem_wr;
               r_state <= i_need_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
               if (i_mem_ready)
                  r_state <= S_WB;
               else if (TO_EN && (r_wait == LAST_WAIT))
                  r_state <= S_ERR;
               else
                  r_wait <= r_wait + 1'b1;
            end
            S_WB: begin
               r_cnt   <= r_cnt + 1'b1;
               r_state <= i_halt_req ? S_HALT : S_FETCH;
            end
            S_HALT: begin
               if (!i_halt_req)
                  r_state <= S_FETCH;
            end
            S_ERR: begin
               r_state <= S_ERR;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // The strobes and status flags decode only from registered state and
   // flags, so no input has a combinational path to an output. In MEM the
   // need flag is always set; including it keeps the strobe tied to an
   // instruction that actually asked for memory.
   always_comb begin
      o_read  = (r_state == S_FETCH) ||
                ((r_state == S_MEM) && r_need && !r_store);
      o_write = (r_state == S_MEM) && r_need && r_store;
   end

   assign o_state    = r_state;
   assign o_insn_cnt = r_cnt;
   assign o_bus_err  = (r_state == S_ERR);
   assign o_halted   = (r_state == S_HALT);

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// TbProcSeqCtrl -- directed testbench for proc_seq_ctrl.
// The DUT uses a 4-bit instruction counter so that counter wrap is reachable.
// It keeps the default 15-cycle memory timeout.
// ---------------------------------------------------------------------------
module tb_proc_seq_ctrl;

   logic       clock;
   logic       reset;
   logic       memReady;
   logic       stall;
   logic       needMem;
   logic       memWr;
   logic       haltReq;
   logic [2:0] state;
   logic       readStb;
   logic       writeStb;
   logic [3:0] insnCnt;
   logic       busErr;
   logic       halted;

   int assertCount = 0;
   int failCount   = 0;

   proc_seq_ctrl #(
      .CNT_WIDTH (4),
      .TIMEOUT   (15),
      .TO_WIDTH  (4)
   ) dut (
      .i_clk       (clock),
      .i_rst       (reset),
      .i_mem_ready (memReady),
      .i_stall     (stall),
      .i_need_mem  (needMem),
      .i_mem_wr    (memWr),
      .i_halt_req  (haltReq),
      .o_state     (state),
      .o_read      (readStb),
      .o_write     (writeStb),
      .o_insn_cnt  (insnCnt),
      .o_bus_err   (busErr),
      .o_halted    (halted)
   );

   // 10-time-unit clock period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance n rising edges. Outputs are then settled, 1 unit after the edge.
   task automatic applyStimulus(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   // One counted comparison, checked with an immediate assertion.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Check the state code together with both memory strobes.
   task automatic checkState(input string tag, input int st, input int rd, input int wr);
      checkOutput({tag, ".state"}, 32'(state), 32'(st));
      checkOutput({tag, ".read"},  32'(readStb), 32'(rd));
      checkOutput({tag, ".write"}, 32'(writeStb), 32'(wr));
   endtask

   initial begin
      reset = 1'b1; memReady = 1'b0; stall = 1'b0;
      needMem = 1'b0; memWr = 1'b0; haltReq = 1'b0;

      // Reset state.
      applyStimulus(2);
      checkState("reset", 7, 0, 0);
      checkOutput("reset.cnt",    32'(insnCnt), 0);
      checkOutput("reset.busErr", 32'(busErr),  0);
      checkOutput("reset.halted", 32'(halted),  0);

      // Non-memory instruction with zero wait states.
      memReady = 1'b1; reset = 1'b0;
      applyStimulus(1); checkState("nm.fetch",  0, 1, 0);
      applyStimulus(1); checkState("nm.decode", 1, 0, 0);
      applyStimulus(1); checkState("nm.exe",    2, 0, 0);
      applyStimulus(1); checkState("nm.wb",     4, 0, 0);
      checkOutput("nm.cntInWb", 32'(insnCnt), 0);
      applyStimulus(1); checkState("nm.fetch2", 0, 1, 0);
      checkOutput("nm.cnt", 32'(insnCnt), 1);

      // Store instruction.
      needMem = 1'b1; memWr = 1'b1;
      applyStimulus(2); checkState("st.exe", 2, 0, 0);
      applyStimulus(1); checkState("st.mem", 3, 0, 1);
      applyStimulus(1); checkState("st.wb",  4, 0, 0);
      applyStimulus(1); checkState("st.fetch", 0, 1, 0);
      checkOutput("st.cnt", 32'(insnCnt), 2);

      // Load instruction.
      memWr = 1'b0;
      applyStimulus(3); checkState("ld.mem", 3, 1, 0);
      applyStimulus(2); checkState("ld.fetch", 0, 1, 0);
      checkOutput("ld.cnt", 32'(insnCnt), 3);

      // Fetch wait states, then a stall held in DECODE.
      needMem = 1'b0; memReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1); checkState("ws.fetchHeld", 0, 1, 0);
      end
      memReady = 1'b1; stall = 1'b1;
      applyStimulus(1); checkState("ws.decode", 1, 0, 0);
      applyStimulus(2); checkState("ws.decodeHeld", 1, 0, 0);
      stall = 1'b0;
      applyStimulus(1); checkState("ws.exe", 2, 0, 0);
      applyStimulus(2); checkOutput("ws.cnt", 32'(insnCnt), 4);

      // Halt request in WB.
      applyStimulus(2); haltReq = 1'b1;
      applyStimulus(1); checkState("h.wb", 4, 0, 0);
      applyStimulus(1); checkOutput("h.state", 32'(state), 5);
      checkOutput("h.halted", 32'(halted), 1);
      checkOutput("h.cnt", 32'(insnCnt), 5);
      applyStimulus(2); checkOutput("h.held", 32'(state), 5);
      checkOutput("h.cntHeld", 32'(insnCnt), 5);
      haltReq = 1'b0;
      applyStimulus(1); checkState("h.resume", 0, 1, 0);
      checkOutput("h.haltedClr", 32'(halted), 0);

      // Fetch timeout leads to ERR after exactly 15 FETCH cycles.
      memReady = 1'b0;
      applyStimulus(14); checkState("to.fetch15", 0, 1, 0);
      applyStimulus(1);  checkState("to.err", 6, 0, 0);
      checkOutput("to.busErr", 32'(busErr), 1);
      memReady = 1'b1; stall = 1'b1; haltReq = 1'b1;
      applyStimulus(3); checkOutput("to.errSticky", 32'(state), 6);
      stall = 1'b0; haltReq = 1'b0;
      reset = 1'b1;
      applyStimulus(1); checkOutput("to.rstState", 32'(state), 7);
      checkOutput("to.rstBusErr", 32'(busErr), 0);
      checkOutput("to.rstCnt", 32'(insnCnt), 0);

      // Ready arrives on the 15th FETCH cycle, so no error is raised.
      reset = 1'b0; memReady = 1'b0;
      applyStimulus(1);  checkState("tr.fetch", 0, 1, 0);
      applyStimulus(14); checkState("tr.fetch15", 0, 1, 0);
      memReady = 1'b1;
      applyStimulus(1); checkState("tr.decode", 1, 0, 0);
      checkOutput("tr.busErr", 32'(busErr), 0);

      // The 4-bit counter wraps after 16 retired instructions.
      applyStimulus(3); checkOutput("wr.cnt1", 32'(insnCnt), 1);
      applyStimulus(4 * 14); checkOutput("wr.cnt15", 32'(insnCnt), 15);
      applyStimulus(4); checkOutput("wr.cntWrap", 32'(insnCnt), 0);
      checkState("wr.fetch", 0, 1, 0);

      // Reset asserted in the middle of a store MEM cycle.
      needMem = 1'b1; memWr = 1'b1;
      applyStimulus(3); checkState("rm.mem", 3, 0, 1);
      reset = 1'b1;
      applyStimulus(1); checkState("rm.idle", 7, 0, 0);
      applyStimulus(2); checkState("rm.held", 7, 0, 0);
      checkOutput("rm.cnt", 32'(insnCnt), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
